// File: rtl/pc_pkg.sv
// pc_pkg: shared definitions for the program-counter unit.
//   - pcsrc_e: next-PC select encoding (PCSRC_PLUS4/BRANCH/JALR/RET)
//   - DEFAULT_RESET_VECTOR: default PC after reset and while idle
package pc_pkg;

  typedef enum logic [1:0] {
    PCSRC_PLUS4  = 2'b00,
    PCSRC_BRANCH = 2'b01,
    PCSRC_JALR   = 2'b10,
    PCSRC_RET    = 2'b11
  } pcsrc_e;

  // Wide enough for any sensible ADDRESS_WIDTH; truncated at the use site.
  localparam logic [63:0] DEFAULT_RESET_VECTOR = 64'h0;

endpackage

// File: rtl/pc_unit_if.sv
// pc_unit_if: control/status bundle between the fetch controller and pc_unit.
//   master (controller): drives trigger, stall, pcsrc, immext, result, call;
//                        observes pc, pcplus4, ras_empty, ras_overflow.
//   slave  (pc_unit)   : the mirror image.
interface pc_unit_if #(
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned DATA_WIDTH    = 32
);
  logic                     trigger;
  logic                     stall;
  logic [1:0]               pcsrc;
  logic [DATA_WIDTH-1:0]    immext;
  logic [DATA_WIDTH-1:0]    result;
  logic                     call;
  logic [ADDRESS_WIDTH-1:0] pc;
  logic [ADDRESS_WIDTH-1:0] pcplus4;
  logic                     ras_empty;
  logic                     ras_overflow;

  modport master (
    output trigger, stall, pcsrc, immext, result, call,
    input  pc, pcplus4, ras_empty, ras_overflow
  );

  modport slave (
    input  trigger, stall, pcsrc, immext, result, call,
    output pc, pcplus4, ras_empty, ras_overflow
  );
endinterface

// File: rtl/return_addr_stack.sv
// return_addr_stack: circular return-address stack.
//   clk, rst    : clock, asynchronous active-high reset (clears all state)
//   push_i      : write data_i as the new top entry
//   pop_i       : discard the top entry (ignored when empty)
//   data_i      : address to push
//   top_o       : current top entry (meaningless when empty_o)
//   empty_o     : no entries held
//   overflow_o  : sticky, set when a push overwrote the oldest entry
// Push and pop together replace the top entry in place.
module return_addr_stack #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] top_o,
  output logic             empty_o,
  output logic             overflow_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam logic [PtrW:0] CountFull = (PtrW + 1)'(DEPTH);

  logic [WIDTH-1:0] entries_q [DEPTH];
  logic [WIDTH-1:0] entries_d [DEPTH];
  // ptr_q is the next free slot; the top entry sits one below it (mod DEPTH).
  logic [PtrW-1:0]  ptr_q, ptr_d, top_idx;
  logic [PtrW:0]    count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             do_pop;

  assign top_idx    = ptr_q - PtrW'(1);
  assign do_pop     = pop_i & (count_q != '0);
  assign top_o      = entries_q[top_idx];
  assign empty_o    = (count_q == '0);
  assign overflow_o = ovf_q;

  always_comb begin
    entries_d = entries_q;
    ptr_d     = ptr_q;
    count_d   = count_q;
    ovf_d     = ovf_q;
    if (push_i && do_pop) begin
      entries_d[top_idx] = data_i;
    end else if (push_i) begin
      entries_d[ptr_q] = data_i;
      ptr_d            = ptr_q + PtrW'(1);
      // When full the write lands on the oldest entry; count saturates.
      if (count_q == CountFull) begin
        ovf_d = 1'b1;
      end else begin
        count_d = count_q + (PtrW + 1)'(1);
      end
    end else if (do_pop) begin
      ptr_d   = top_idx;
      count_d = count_q - (PtrW + 1)'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        entries_q[i] <= '0;
      end
      ptr_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      entries_q <= entries_d;
      ptr_q     <= ptr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
    end
  end

endmodule

// File: rtl/pc_unit.sv
// pc_unit: program counter with optional return-address stack.
//   clk, rst : clock, asynchronous active-high reset
//   pc_if    : pc_unit_if.slave
//     trigger=0 holds pc at RESET_VECTOR; stall=1 holds pc and RAS;
//     pcsrc selects plus4 / branch (pc+sext(immext)) / jump-register
//     (result, bit 0 cleared) / return (RAS top, pcplus4 if empty);
//     call pushes pcplus4 on an advancing cycle.
//     pc is registered, pcplus4 is combinational.
// Build option: define PC_UNIT_RAS_EN to include the RAS. Without it
// return behaves as jump-register, call is ignored, ras_empty=1 and
// ras_overflow=0.
module pc_unit
  import pc_pkg::*;
#(
  parameter int unsigned              ADDRESS_WIDTH = 32,
  parameter int unsigned              DATA_WIDTH    = 32,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_VECTOR  = ADDRESS_WIDTH'(DEFAULT_RESET_VECTOR),
  parameter int unsigned              RAS_DEPTH     = 4
) (
  input  logic      clk,
  input  logic      rst,
  pc_unit_if.slave  pc_if
);

  logic [ADDRESS_WIDTH-1:0] pc_q, pc_d;
  logic [ADDRESS_WIDTH-1:0] pcplus4;
  logic [ADDRESS_WIDTH-1:0] imm_sext;
  logic [ADDRESS_WIDTH-1:0] res_addr;
  logic [ADDRESS_WIDTH-1:0] jalr_target;
  logic [ADDRESS_WIDTH-1:0] ret_target;
  logic [ADDRESS_WIDTH-1:0] next_pc;
  logic                     advance;
  logic                     ras_empty;
  logic                     ras_overflow;

  assign pcplus4 = pc_q + ADDRESS_WIDTH'(4);
  assign advance = pc_if.trigger & ~pc_if.stall;

  // Fit data-width operands to the address width.
  if (DATA_WIDTH >= ADDRESS_WIDTH) begin : g_narrow
    assign imm_sext = pc_if.immext[ADDRESS_WIDTH-1:0];
    assign res_addr = pc_if.result[ADDRESS_WIDTH-1:0];
  end else begin : g_widen
    assign imm_sext = {{(ADDRESS_WIDTH - DATA_WIDTH){pc_if.immext[DATA_WIDTH-1]}},
                       pc_if.immext};
    assign res_addr = {{(ADDRESS_WIDTH - DATA_WIDTH){1'b0}}, pc_if.result};
  end

  assign jalr_target = res_addr & ~ADDRESS_WIDTH'(1);

`ifdef PC_UNIT_RAS_EN
  logic                     ras_push;
  logic                     ras_pop;
  logic [ADDRESS_WIDTH-1:0] ras_top;

  assign ras_push = advance & pc_if.call;
  assign ras_pop  = advance & (pcsrc_e'(pc_if.pcsrc) == PCSRC_RET) & ~ras_empty;

  return_addr_stack #(
    .WIDTH (ADDRESS_WIDTH),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk        (clk),
    .rst        (rst),
    .push_i     (ras_push),
    .pop_i      (ras_pop),
    .data_i     (pcplus4),
    .top_o      (ras_top),
    .empty_o    (ras_empty),
    .overflow_o (ras_overflow)
  );

  assign ret_target = ras_empty ? pcplus4 : ras_top;
`else
  localparam int unsigned unused_ras_depth = RAS_DEPTH;
  logic unused_call;

  assign unused_call  = pc_if.call;
  assign ras_empty    = 1'b1;
  assign ras_overflow = 1'b0;
  assign ret_target   = jalr_target;
`endif

  always_comb begin
    next_pc = pcplus4;
    unique case (pcsrc_e'(pc_if.pcsrc))
      PCSRC_PLUS4:  next_pc = pcplus4;
      PCSRC_BRANCH: next_pc = pc_q + imm_sext;
      PCSRC_JALR:   next_pc = jalr_target;
      PCSRC_RET:    next_pc = ret_target;
      default:      next_pc = pcplus4;
    endcase
  end

  always_comb begin
    pc_d = next_pc;
    if (!pc_if.trigger) begin
      pc_d = RESET_VECTOR;
    end else if (pc_if.stall) begin
      pc_d = pc_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= RESET_VECTOR;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_if.pc           = pc_q;
  assign pc_if.pcplus4      = pcplus4;
  assign pc_if.ras_empty    = ras_empty;
  assign pc_if.ras_overflow = ras_overflow;

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: scoreboard bench for pc_unit (RAS_DEPTH=4, RESET_VECTOR=0).
// Stimulus pushes the hand-computed state expected after the next edge;
// a monitor pops and compares one entry per cycle. Expectations follow
// the PC_UNIT_RAS_EN build option.
module tb_pc_unit;
  import pc_pkg::*;

`ifdef PC_UNIT_RAS_EN
  localparam bit RAS = 1'b1;
`else
  localparam bit RAS = 1'b0;
`endif

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic        empty;
    logic        ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  exp_t sb_q[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;

  logic [31:0] call_tgt [5] = '{32'h20, 32'h30, 32'h40, 32'h50, 32'h200};
  logic [31:0] ret_pc   [4] = '{32'h54, 32'h44, 32'h34, 32'h24};

  pc_unit_if #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) pif ();

  pc_unit #(
    .ADDRESS_WIDTH (32),
    .DATA_WIDTH    (32),
    .RESET_VECTOR  (32'h0),
    .RAS_DEPTH     (4)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .pc_if (pif)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step(input string name, input logic trig, input logic stl,
                      input logic [1:0] src, input logic [31:0] imm, input logic [31:0] res,
                      input logic cl, input logic [31:0] epc, input logic eempty,
                      input logic eovf);
    @(negedge clk);
    pif.trigger = trig;
    pif.stall   = stl;
    pif.pcsrc   = src;
    pif.immext  = imm;
    pif.result  = res;
    pif.call    = cl;
    sb_q.push_back('{name: name, pc: epc, empty: eempty, ovf: eovf});
  endtask

  // Monitor: one expectation per edge, sampled just after it.
  always @(posedge clk) begin
    #1;
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      chk({mon_e.name, "/pc"}, pif.pc, mon_e.pc);
      chk({mon_e.name, "/pcplus4"}, pif.pcplus4, mon_e.pc + 32'd4);
      chk({mon_e.name, "/empty"}, 32'(pif.ras_empty), 32'(mon_e.empty));
      chk({mon_e.name, "/ovf"}, 32'(pif.ras_overflow), 32'(mon_e.ovf));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    pif.trigger = 1'b0;
    pif.stall   = 1'b0;
    pif.pcsrc   = 2'b00;
    pif.immext  = '0;
    pif.result  = '0;
    pif.call    = 1'b0;
    #3;
    chk("reset/pc", pif.pc, 32'h0);
    chk("reset/empty", 32'(pif.ras_empty), 32'h1);
    chk("reset/ovf", 32'(pif.ras_overflow), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    //   name          trg stl src    immext         result      call exp pc
    step("idle",       0, 0, 2'b00, 32'h0,        32'h0,       0, 32'h0,   1'b1, 1'b0);
    step("seq1",       1, 0, 2'b00, 32'h0,        32'h0,       0, 32'h4,   1'b1, 1'b0);
    step("seq2",       1, 0, 2'b00, 32'h0,        32'h0,       0, 32'h8,   1'b1, 1'b0);
    step("seq3",       1, 0, 2'b00, 32'h0,        32'h0,       0, 32'hC,   1'b1, 1'b0);
    step("stall",      1, 1, 2'b00, 32'h0,        32'h0,       0, 32'hC,   1'b1, 1'b0);
    step("stall_call", 1, 1, 2'b10, 32'h0,        32'h500,     1, 32'hC,   1'b1, 1'b0);
    step("jr_100",     1, 0, 2'b10, 32'h0,        32'h100,     0, 32'h100, 1'b1, 1'b0);
    step("br_m8",      1, 0, 2'b01, 32'hFFFFFFF8, 32'h0,       0, 32'hF8,  1'b1, 1'b0);
    step("jr_2001",    1, 0, 2'b10, 32'h0,        32'h2001,    0, 32'h2000, 1'b1, 1'b0);
    step("jr_40",      1, 0, 2'b10, 32'h0,        32'h40,      0, 32'h40,  1'b1, 1'b0);
    step("call_40",    1, 0, 2'b10, 32'h0,        32'h80,      1, 32'h80,  ~RAS, 1'b0);
    step("ret_44",     1, 0, 2'b11, 32'h0,        32'h300,     0,
         RAS ? 32'h44 : 32'h300, 1'b1, 1'b0);
    step("idle_call",  0, 0, 2'b00, 32'h0,        32'h0,       1, 32'h0,   1'b1, 1'b0);
    step("br_wrap",    1, 0, 2'b01, 32'hFFFFFFFC, 32'h0,       0, 32'hFFFFFFFC, 1'b1, 1'b0);
    step("plus4_wrap", 1, 0, 2'b00, 32'h0,        32'h0,       0, 32'h0,   1'b1, 1'b0);
    step("jr_10",      1, 0, 2'b10, 32'h0,        32'h10,      0, 32'h10,  1'b1, 1'b0);

    // Five calls into a 4-deep stack: the fifth overwrites the oldest.
    for (int i = 0; i < 5; i++) begin
      step($sformatf("call%0d", i), 1, 0, 2'b10, 32'h0, call_tgt[i], 1, call_tgt[i],
           ~RAS, RAS & (i == 4));
    end
    for (int i = 0; i < 4; i++) begin
      step($sformatf("ret%0d", i), 1, 0, 2'b11, 32'h0, 32'h300, 0,
           RAS ? ret_pc[i] : 32'h300, ~RAS | (i == 3), RAS);
    end
    step("ret_empty",  1, 0, 2'b11, 32'h0, 32'h300, 0, RAS ? 32'h28 : 32'h300, 1'b1, RAS);

    // Push and pop together replace the top entry.
    step("call_600",   1, 0, 2'b10, 32'h0, 32'h600, 1, 32'h600, ~RAS, RAS);
    step("call_ret",   1, 0, 2'b11, 32'h0, 32'h700, 1, RAS ? 32'h2C : 32'h700, ~RAS, RAS);
    step("stall_ret",  1, 1, 2'b11, 32'h0, 32'h300, 0, RAS ? 32'h2C : 32'h700, ~RAS, RAS);
    step("ret_604",    1, 0, 2'b11, 32'h0, 32'h300, 0, RAS ? 32'h604 : 32'h300, 1'b1, RAS);

    // Asynchronous reset with a push pending.
    @(negedge clk);
    pif.trigger = 1'b1;
    pif.stall   = 1'b0;
    pif.pcsrc   = 2'b10;
    pif.result  = 32'h900;
    pif.call    = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    chk("midrst/pc", pif.pc, 32'h0);
    chk("midrst/empty", 32'(pif.ras_empty), 32'h1);
    chk("midrst/ovf", 32'(pif.ras_overflow), 32'h0);
    @(negedge clk);
    rst         = 1'b0;
    pif.trigger = 1'b0;
    pif.call    = 1'b0;
    step("rst_seq",    1, 0, 2'b00, 32'h0, 32'h0,   0, 32'h4, 1'b1, 1'b0);
    step("rst_ret",    1, 0, 2'b11, 32'h0, 32'h300, 0, RAS ? 32'h8 : 32'h300, 1'b1, 1'b0);

    repeat (3) @(negedge clk);
    chk("drain", 32'(sb_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
